// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: default byte width, bit timing,
// and the feeder state encoding.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int CLOCKS_PER_BIT  = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARM       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO whose read port is a register that updates only on a pop,
// so the popped word stays stable until the next pop.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_pop,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_level = r_level;
  assign o_data  = r_data;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_data   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART,
// asserting enable only while the UART is idle and holding data for the frame.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int ARM_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     uart_enable,
  output logic [DATA_WIDTH-1:0]    uart_data,
  input  logic                     uart_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     tx_done,
  output logic                     arm_error
);

  localparam int TW = $clog2(ARM_TIMEOUT);

  logic [1:0]    r_state;
  logic [TW-1:0] r_tmo;
  logic          r_tx_done;
  logic          r_arm_error;
  logic          w_full;
  logic          w_empty;
  logic          w_launch;

  assign w_launch = (r_state == ST_IDLE) && !w_empty && !uart_busy;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (s_valid),
    .i_data  (s_data),
    .i_pop   (w_launch),
    .o_data  (uart_data),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_ready     = !w_full;
  // Combinational so enable drops in the same cycle busy rises.
  assign uart_enable = (r_state == ST_ARM) && !uart_busy;
  assign tx_done     = r_tx_done;
  assign arm_error   = r_arm_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tmo       <= '0;
      r_tx_done   <= 1'b0;
      r_arm_error <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state <= ST_ARM;
            r_tmo   <= '0;
          end
        end
        ST_ARM: begin
          if (uart_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_tmo == TW'(ARM_TIMEOUT - 1)) begin
            // UART never acknowledged; drop the byte and carry on.
            r_arm_error <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_busy) begin
            r_tx_done <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder driving a behavioural UART that records
// each transmitted byte at the end of its frame.
module tb_uart_tx_feeder;

  localparam int FRAME = 10 * 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       uart_enable;
  logic [7:0] uart_data;
  logic       uart_busy;
  logic [4:0] level;
  logic       tx_done;
  logic       arm_error;

  int vectors = 0;
  int miscompares = 0;

  logic       stub = 1'b0;
  logic [7:0] r_cap;
  int         r_cnt;
  logic [7:0] rx_mem [64];
  int         rx_count = 0;
  logic [7:0] exp_mem [64];
  int         exp_count = 0;
  int         done_cnt = 0;
  int         overlap_cnt = 0;
  int         unstable_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .uart_enable (uart_enable),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .level       (level),
    .tx_done     (tx_done),
    .arm_error   (arm_error)
  );

  // Behavioural UART: goes busy one cycle after enable, stays busy FRAME cycles.
  always @(posedge clk) begin
    if (reset) begin
      uart_busy <= 1'b0;
      r_cnt     <= 0;
    end else if (uart_busy) begin
      if (r_cnt == 0) begin
        uart_busy          <= 1'b0;
        rx_mem[rx_count]   <= r_cap;
        rx_count           <= rx_count + 1;
      end else begin
        r_cnt <= r_cnt - 1;
      end
    end else if (uart_enable && !stub) begin
      uart_busy <= 1'b1;
      r_cap     <= uart_data;
      r_cnt     <= FRAME - 1;
    end
  end

  always @(posedge clk) if (tx_done) done_cnt <= done_cnt + 1;

  always @(negedge clk) begin
    if (uart_enable && uart_busy) overlap_cnt <= overlap_cnt + 1;
    if (uart_busy && !reset && uart_data !== r_cap) unstable_cnt <= unstable_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, input bit expect_rx);
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
    if (expect_rx) begin
      exp_mem[exp_count] = b;
      exp_count++;
    end
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 100 && !uart_busy; i++) step();
    check(tag, {31'd0, uart_busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !tx_done; i++) step();
    check(tag, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int n);
    for (int i = 0; i < 3000 && rx_count < n; i++) step();
    check(tag, rx_count, n);
    step(5);
  endtask

  initial begin
    int cnt;
    int bad;
    int base_done;
    int base_rx;

    // Reset state
    step(2);
    check("rst_level", level, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_enable", uart_enable, 0);
    check("rst_data", uart_data, 0);
    check("rst_arm_error", arm_error, 0);
    reset = 1'b0;
    step();

    // 1: single byte, launch latency and data hold
    push(8'hA5, 1);
    check("t1_level_after_push", level, 1);
    check("t1_enable_before_launch", uart_enable, 0);
    step();
    check("t1_enable_in_arm", uart_enable, 1);
    check("t1_uart_data", uart_data, 32'hA5);
    check("t1_level_after_pop", level, 0);
    step();
    check("t1_busy", uart_busy, 1);
    check("t1_enable_drops", uart_enable, 0);
    bad = 0;
    for (int i = 0; i < 200 && !tx_done; i++) begin
      if (uart_data !== 8'hA5) bad++;
      step();
    end
    check("t1_tx_done", tx_done, 1);
    check("t1_data_stable", bad, 0);
    step();
    check("t1_tx_done_one_cycle", tx_done, 0);
    check("t1_rx_count", rx_count, 1);
    step(3);

    // 2: three back-to-back bytes
    base_done = done_cnt;
    push(8'h01, 1);
    push(8'h02, 1);
    push(8'h03, 1);
    wait_rx("t2_rx", 4);
    check("t2_done_pulses", done_cnt - base_done, 3);
    check("t2_level", level, 0);

    // 3: fill while busy, 17th push held off until first pop
    push(8'h10, 1);
    wait_busy("t3_busy");
    for (int i = 0; i < 16; i++) push(8'h11 + 8'(i), 1);
    check("t3_level_full", level, 16);
    check("t3_s_ready_full", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 8'h21;
    cnt = 0;
    while (!s_ready && cnt < 500) begin
      step();
      cnt++;
    end
    check("t3_ready_returns", s_ready, 1);
    step();
    s_valid = 1'b0;
    exp_mem[exp_count] = 8'h21;
    exp_count++;
    check("t3_level_refilled", level, 16);
    wait_rx("t3_rx", exp_count);

    // 6: push and pop on the same edge at level 8
    push(8'h60, 1);
    wait_busy("t6_busy");
    for (int i = 0; i < 8; i++) push(8'h61 + 8'(i), 1);
    check("t6_level8", level, 8);
    wait_done("t6_done");
    s_valid = 1'b1;
    s_data  = 8'h69;
    step();
    s_valid = 1'b0;
    exp_mem[exp_count] = 8'h69;
    exp_count++;
    check("t6_level_same_edge", level, 8);
    check("t6_enable", uart_enable, 1);
    wait_rx("t6_rx", exp_count);

    // 4: UART stubbed, arm timeout
    stub = 1'b1;
    push(8'hEE, 0);
    step();
    cnt = 0;
    while (uart_enable && cnt < 200) begin
      cnt++;
      step();
    end
    check("t4_arm_cycles", cnt, 64);
    check("t4_arm_error", arm_error, 1);
    check("t4_level", level, 0);
    stub = 1'b0;
    step(2);
    push(8'h5A, 1);
    wait_rx("t4_rx_after_error", exp_count);
    check("t4_arm_error_sticky", arm_error, 1);

    // Stability and handshake invariants over all traffic so far
    check("enable_busy_overlap", overlap_cnt, 0);
    check("data_unstable", unstable_cnt, 0);
    check("rx_total", rx_count, exp_count);
    for (int i = 0; i < exp_count; i++) begin
      check($sformatf("rx_byte_%0d", i), rx_mem[i], exp_mem[i]);
    end

    // 5: reset during WAIT_DONE with level 5
    push(8'h70, 0);
    wait_busy("t5_busy");
    step(2);
    for (int i = 0; i < 5; i++) push(8'h71 + 8'(i), 0);
    check("t5_level5", level, 5);
    base_done = done_cnt;
    base_rx   = rx_count;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_level", level, 0);
    check("t5_s_ready", s_ready, 1);
    check("t5_enable", uart_enable, 0);
    check("t5_arm_error", arm_error, 0);
    step(60);
    check("t5_no_tx_done", done_cnt - base_done, 0);
    check("t5_no_rx", rx_count - base_rx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
